alu_tx_sequencer: RTL and testbench

//  Sequences one ALU transaction per received operand set: latches A/B/OP from
//  the UART receive interface, drives them to the ALU, waits a fixed ALU latency,

---
 rtl/alu_tx_sequencer_pkg.sv | 20 ++
 rtl/alu_tx_sequencer_seq_timer.sv | 32 +++
 rtl/alu_tx_sequencer.sv | 159 +++++++++++++++
 tb/tb_alu_tx_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_tx_sequencer_pkg.sv
// Shared definitions for the ALU transaction sequencer: state encoding,
// default data width and response frame layout.
package alu_tx_sequencer_pkg;

    localparam int DBIT_DEFAULT = 8;
    localparam int FRAME_BYTES  = 2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_ALU = 3'd1,
        ST_SEND     = 3'd2,
        ST_WAIT_TX  = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    typedef logic [$clog2(FRAME_BYTES)-1:0] byte_idx_t;

    localparam byte_idx_t LAST_BYTE = byte_idx_t'(FRAME_BYTES - 1);

endpackage

// File: rtl/alu_tx_sequencer_seq_timer.sv
// Loadable up/down counter that stops at, and flags, a fixed terminal count.
// Used for the ALU latency wait and for the tx handshake timeout.
module alu_tx_sequencer_seq_timer #(
    parameter int WIDTH    = 4,
    parameter int TERM     = 0,
    parameter bit COUNT_UP = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_terminal
);

    logic [WIDTH-1:0] count_q;

    assign o_terminal = (count_q == WIDTH'(TERM));

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every register samples the pre-edge value of every other register.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            count_q <= '0;
        end else if (i_load) begin
            count_q <= i_load_val;
        end else if (i_en && !o_terminal) begin
            count_q <= COUNT_UP ? count_q + 1'b1 : count_q - 1'b1;
        end
    end

endmodule

// File: rtl/alu_tx_sequencer.sv
// Runs one ALU transaction per received operand set and sends the 2-byte
// response frame (result, checksum) through the UART tx start/done handshake.
module alu_tx_sequencer
    import alu_tx_sequencer_pkg::*;
#(
    parameter int DBIT       = DBIT_DEFAULT,
    parameter int ALU_LAT    = 1,
    parameter int TX_TIMEOUT = 4096
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_rx_alu_done,
    input  logic [DBIT-1:0] i_a,
    input  logic [DBIT-1:0] i_b,
    input  logic [DBIT-1:0] i_op,
    output logic [DBIT-1:0] o_alu_a,
    output logic [DBIT-1:0] o_alu_b,
    output logic [DBIT-1:0] o_alu_op,
    input  logic [DBIT-1:0] i_alu_result,
    output logic [DBIT-1:0] o_tx_data,
    output logic            o_tx_start,
    input  logic            i_tx_done,
    input  logic            i_clr_err,
    output logic            o_busy,
    output logic            o_seq_done,
    output logic            o_overrun,
    output logic            o_tx_err
);

    localparam int LAT_W = $clog2(ALU_LAT + 1);
    localparam int TO_W  = $clog2(TX_TIMEOUT + 1);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(ALU_LAT - 1);
    localparam logic [TO_W-1:0]  TO_LOAD  = '0;

    function automatic logic [DBIT-1:0] frame_checksum(
        input logic [DBIT-1:0] a,
        input logic [DBIT-1:0] b,
        input logic [DBIT-1:0] op,
        input logic [DBIT-1:0] res
    );
        return a ^ b ^ op ^ res;
    endfunction

    state_t          state_q, state_d;
    byte_idx_t       byte_idx_q;
    logic [DBIT-1:0] result_q;
    logic            lat_load, lat_en, lat_done;
    logic            to_load, to_en, to_expired;
    logic            capture_ops, capture_result, next_byte, tx_abort, overrun_evt;

    alu_tx_sequencer_seq_timer #(
        .WIDTH    (LAT_W),
        .TERM     (0),
        .COUNT_UP (1'b0)
    ) u_lat_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (lat_load),
        .i_load_val (LAT_LOAD),
        .i_en       (lat_en),
        .o_terminal (lat_done)
    );

    alu_tx_sequencer_seq_timer #(
        .WIDTH    (TO_W),
        .TERM     (TX_TIMEOUT - 1),
        .COUNT_UP (1'b1)
    ) u_tx_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (to_load),
        .i_load_val (TO_LOAD),
        .i_en       (to_en),
        .o_terminal (to_expired)
    );

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        lat_load = 1'b0;
        lat_en   = 1'b0;
        to_load  = 1'b0;
        to_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_rx_alu_done) begin
                    state_d  = ST_WAIT_ALU;
                    lat_load = 1'b1;
                end
            end
            ST_WAIT_ALU: begin
                if (lat_done) state_d = ST_SEND;
                else          lat_en  = 1'b1;
            end
            ST_SEND: begin
                to_load = 1'b1;
                state_d = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                // A done arriving on the timeout cycle still completes the byte.
                if (i_tx_done)       state_d = (byte_idx_q == LAST_BYTE) ? ST_DONE : ST_SEND;
                else if (to_expired) state_d = ST_IDLE;
                else                 to_en   = 1'b1;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    assign capture_ops    = (state_q == ST_IDLE) && i_rx_alu_done;
    assign capture_result = (state_q == ST_WAIT_ALU) && lat_done;
    assign next_byte      = (state_q == ST_WAIT_TX) && i_tx_done && (byte_idx_q != LAST_BYTE);
    assign tx_abort       = (state_q == ST_WAIT_TX) && !i_tx_done && to_expired;
    assign overrun_evt    = i_rx_alu_done && (state_q != ST_IDLE);

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            o_alu_a    <= '0;
            o_alu_b    <= '0;
            o_alu_op   <= '0;
            result_q   <= '0;
            o_tx_data  <= '0;
            byte_idx_q <= '0;
            o_overrun  <= 1'b0;
            o_tx_err   <= 1'b0;
        end else begin
            if (capture_ops) begin
                o_alu_a    <= i_a;
                o_alu_b    <= i_b;
                o_alu_op   <= i_op;
                byte_idx_q <= '0;
            end
            if (capture_result) begin
                result_q  <= i_alu_result;
                o_tx_data <= i_alu_result;
            end
            if (next_byte) begin
                byte_idx_q <= byte_idx_q + 1'b1;
                o_tx_data  <= frame_checksum(o_alu_a, o_alu_b, o_alu_op, result_q);
            end
            // A new error event outranks a clear in the same cycle.
            if (overrun_evt)    o_overrun <= 1'b1;
            else if (i_clr_err) o_overrun <= 1'b0;
            if (tx_abort)       o_tx_err  <= 1'b1;
            else if (i_clr_err) o_tx_err  <= 1'b0;
        end
    end

    assign o_tx_start = (state_q == ST_SEND);
    assign o_seq_done = (state_q == ST_DONE);
    assign o_busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_tx_sequencer.sv
// Bench for alu_tx_sequencer: two instances (ALU latency 1 and 3) checked every
// cycle against a timestamp-based frame model, plus hand-computed scenario checks.
module tb_alu_tx_sequencer;

    localparam int DBIT = 8;
    localparam int TO   = 16;
    localparam int NEVER = 1 << 30;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx = 1'b0;
    logic clr = 1'b0;
    logic [7:0] a = '0, b = '0, op = '0;
    logic tx_done [2];
    logic [7:0] alu_res [2];
    logic [7:0] alu_a [2], alu_b [2], alu_op [2], tx_data [2];
    logic tx_start [2], busy [2], seq_done [2], overrun [2], tx_err [2];
    logic [7:0] pipe1, pipe2;

    int cyc = 0;
    int n_checks = 0;
    int n_err = 0;
    int resp_mode = 1;  // 0 random done, 1 done 3 cycles after start, 2 never

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] alu_fn(input logic [7:0] x, input logic [7:0] y, input logic [7:0] o);
        case (o[1:0])
            2'd0:    return x + y;
            2'd1:    return x - y;
            2'd2:    return x & y;
            default: return x ^ y;
        endcase
    endfunction

    // Instance 0 sees a combinational ALU, instance 1 an ALU with two register stages.
    assign alu_res[0] = alu_fn(alu_a[0], alu_b[0], alu_op[0]);
    always @(posedge clk) begin
        pipe1 <= alu_fn(alu_a[1], alu_b[1], alu_op[1]);
        pipe2 <= pipe1;
    end
    assign alu_res[1] = pipe2;

    alu_tx_sequencer #(.DBIT(DBIT), .ALU_LAT(1), .TX_TIMEOUT(TO)) u_lat1 (
        .i_clk(clk), .i_rst(rst_n), .i_rx_alu_done(rx), .i_a(a), .i_b(b), .i_op(op),
        .o_alu_a(alu_a[0]), .o_alu_b(alu_b[0]), .o_alu_op(alu_op[0]), .i_alu_result(alu_res[0]),
        .o_tx_data(tx_data[0]), .o_tx_start(tx_start[0]), .i_tx_done(tx_done[0]), .i_clr_err(clr),
        .o_busy(busy[0]), .o_seq_done(seq_done[0]), .o_overrun(overrun[0]), .o_tx_err(tx_err[0])
    );

    alu_tx_sequencer #(.DBIT(DBIT), .ALU_LAT(3), .TX_TIMEOUT(TO)) u_lat3 (
        .i_clk(clk), .i_rst(rst_n), .i_rx_alu_done(rx), .i_a(a), .i_b(b), .i_op(op),
        .o_alu_a(alu_a[1]), .o_alu_b(alu_b[1]), .o_alu_op(alu_op[1]), .i_alu_result(alu_res[1]),
        .o_tx_data(tx_data[1]), .o_tx_start(tx_start[1]), .i_tx_done(tx_done[1]), .i_clr_err(clr),
        .o_busy(busy[1]), .o_seq_done(seq_done[1]), .o_overrun(overrun[1]), .o_tx_err(tx_err[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Model: a frame is a set of timestamps (busy window, next start, seq_done cycle).
    int m_busy_from [2], m_busy_to [2], m_start_at [2], m_done_at [2], m_last_start [2], m_byte [2];
    bit m_await [2], m_ov [2], m_err [2];
    logic [7:0] m_a [2], m_b [2], m_op [2], m_txd [2];
    logic [7:0] m_frame [2][2];

    // Scenario logs.
    int first_start [2], err_rise [2], done_cnt [2], tx_cnt [2], last_start_seen [2];
    logic [7:0] tx_log [2][4];

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic model_reset(input int i);
        m_busy_from[i] = 1; m_busy_to[i] = 0; m_start_at[i] = -1; m_done_at[i] = -1;
        m_last_start[i] = -1; m_byte[i] = 0; m_await[i] = 0; m_ov[i] = 0; m_err[i] = 0;
        m_a[i] = '0; m_b[i] = '0; m_op[i] = '0; m_txd[i] = '0;
    endtask

    task automatic clear_logs();
        for (int i = 0; i < 2; i++) begin
            first_start[i] = -1; err_rise[i] = -1; done_cnt[i] = 0; tx_cnt[i] = 0;
            for (int k = 0; k < 4; k++) tx_log[i][k] = '0;
        end
    endtask

    task automatic model_cycle(input int i, input int n);
        bit e_busy, e_start, e_done, set_ov, set_err;
        e_busy  = (n >= m_busy_from[i]) && (n <= m_busy_to[i]);
        e_start = (n == m_start_at[i]);
        e_done  = (n == m_done_at[i]);
        if (e_start) m_txd[i] = m_frame[i][m_byte[i]];

        check($sformatf("busy[%0d]@%0d", i, n),     32'(busy[i]),     32'(e_busy));
        check($sformatf("tx_start[%0d]@%0d", i, n), 32'(tx_start[i]), 32'(e_start));
        check($sformatf("seq_done[%0d]@%0d", i, n), 32'(seq_done[i]), 32'(e_done));
        check($sformatf("overrun[%0d]@%0d", i, n),  32'(overrun[i]),  32'(m_ov[i]));
        check($sformatf("tx_err[%0d]@%0d", i, n),   32'(tx_err[i]),   32'(m_err[i]));
        check($sformatf("alu_a[%0d]@%0d", i, n),    32'(alu_a[i]),    32'(m_a[i]));
        check($sformatf("alu_b[%0d]@%0d", i, n),    32'(alu_b[i]),    32'(m_b[i]));
        check($sformatf("alu_op[%0d]@%0d", i, n),   32'(alu_op[i]),   32'(m_op[i]));
        check($sformatf("tx_data[%0d]@%0d", i, n),  32'(tx_data[i]),  32'(m_txd[i]));

        if (!rst_n) begin
            model_reset(i);
        end else begin
            set_ov  = rx && e_busy;
            set_err = 1'b0;
            if (m_await[i]) begin
                if (tx_done[i]) begin
                    m_await[i] = 0;
                    if (m_byte[i] == 0) begin
                        m_byte[i] = 1;
                        m_start_at[i] = n + 1;
                    end else begin
                        m_done_at[i] = n + 1;
                        m_busy_to[i] = n + 1;
                    end
                end else if (n == m_last_start[i] + TO) begin
                    m_await[i] = 0;
                    set_err = 1'b1;
                    m_busy_to[i] = n;
                end
            end
            if (e_start) begin
                m_await[i] = 1;
                m_last_start[i] = n;
            end
            if (rx && !e_busy) begin
                m_a[i] = a; m_b[i] = b; m_op[i] = op;
                m_frame[i][0] = alu_fn(a, b, op);
                m_frame[i][1] = a ^ b ^ op ^ m_frame[i][0];
                m_byte[i] = 0;
                m_busy_from[i] = n + 1;
                m_busy_to[i] = NEVER;
                m_start_at[i] = n + 1 + lat_of(i);
                m_done_at[i] = -1;
            end
            if (set_ov)   m_ov[i] = 1;
            else if (clr) m_ov[i] = 0;
            if (set_err)  m_err[i] = 1;
            else if (clr) m_err[i] = 0;
        end
    endtask

    // Compare and log process: outputs sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (cyc >= 1) begin
                for (int i = 0; i < 2; i++) begin
                    model_cycle(i, cyc);
                    if (tx_start[i] === 1'b1) begin
                        if (tx_cnt[i] < 4) tx_log[i][tx_cnt[i]] = tx_data[i];
                        tx_cnt[i]++;
                        if (first_start[i] < 0) first_start[i] = cyc;
                        last_start_seen[i] = cyc;
                    end
                    if (seq_done[i] === 1'b1) done_cnt[i]++;
                    if (tx_err[i] === 1'b1 && err_rise[i] < 0) err_rise[i] = cyc;
                end
            end
        end
    end

    task automatic step(input bit r, input logic [7:0] ia, input logic [7:0] ib,
                        input logic [7:0] iop, input bit c, input bit rs);
        @(posedge clk);
        #1;
        rx = r; a = ia; b = ib; op = iop; clr = c; rst_n = rs;
        for (int i = 0; i < 2; i++) begin
            case (resp_mode)
                0:       tx_done[i] = ($urandom_range(0, 3) == 0);
                1:       tx_done[i] = (cyc == last_start_seen[i] + 3);
                default: tx_done[i] = 1'b0;
            endcase
        end
    endtask

    task automatic idle(input int k);
        repeat (k) step(1'b0, 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b1);
    endtask

    task automatic check_frame(input string tag, input logic [7:0] b0, input logic [7:0] b1);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s_ntx[%0d]", tag, i),   32'(tx_cnt[i]),   32'd2);
            check($sformatf("%s_byte0[%0d]", tag, i), 32'(tx_log[i][0]), 32'(b0));
            check($sformatf("%s_byte1[%0d]", tag, i), 32'(tx_log[i][1]), 32'(b1));
            check($sformatf("%s_done[%0d]", tag, i),  32'(done_cnt[i]), 32'd1);
        end
    endtask

    initial begin
        int pc;
        tx_done[0] = 1'b0;
        tx_done[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            model_reset(i);
            last_start_seen[i] = -100;
        end
        clear_logs();

        step(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_busy[%0d]", i),  32'(busy[i]),    32'd0);
            check($sformatf("rst_txd[%0d]", i),   32'(tx_data[i]), 32'd0);
            check($sformatf("rst_alu_a[%0d]", i), 32'(alu_a[i]),   32'd0);
        end

        // Basic frame: 5 + 3 = 0x08, checksum 0x2E.
        step(1'b1, 8'h05, 8'h03, 8'h20, 1'b0, 1'b1);
        pc = cyc;
        idle(20);
        check_frame("basic", 8'h08, 8'h2E);
        check("lat1_first_start", 32'(first_start[0] - pc), 32'd2);
        check("lat3_first_start", 32'(first_start[1] - pc), 32'd4);

        // Second operand set lands while both instances sit in WAIT_TX.
        clear_logs();
        step(1'b1, 8'h05, 8'h03, 8'h20, 1'b0, 1'b1);
        idle(4);
        step(1'b1, 8'hFF, 8'h03, 8'h20, 1'b0, 1'b1);
        idle(20);
        check_frame("ovr", 8'h08, 8'h2E);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("ovr_set[%0d]", i),   32'(overrun[i]), 32'd1);
            check($sformatf("ovr_alu_a[%0d]", i), 32'(alu_a[i]),   32'h05);
        end
        step(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
        idle(1);
        for (int i = 0; i < 2; i++) check($sformatf("ovr_clr[%0d]", i), 32'(overrun[i]), 32'd0);

        // Tx core never answers: abort after TO cycles in WAIT_TX.
        resp_mode = 2;
        clear_logs();
        step(1'b1, 8'h05, 8'h03, 8'h20, 1'b0, 1'b1);
        idle(30);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("to_err[%0d]", i),  32'(tx_err[i]),   32'd1);
            check($sformatf("to_busy[%0d]", i), 32'(busy[i]),     32'd0);
            check($sformatf("to_done[%0d]", i), 32'(done_cnt[i]), 32'd0);
            check($sformatf("to_ntx[%0d]", i),  32'(tx_cnt[i]),   32'd1);
            check($sformatf("to_delay[%0d]", i), 32'(err_rise[i] - first_start[i]), 32'(TO + 1));
        end
        step(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
        idle(1);
        for (int i = 0; i < 2; i++) check($sformatf("to_clr[%0d]", i), 32'(tx_err[i]), 32'd0);

        // Reset in the middle of a frame, then a clean frame: 0x10 - 0x22 = 0xEE, checksum 0xFD.
        resp_mode = 1;
        clear_logs();
        step(1'b1, 8'h05, 8'h03, 8'h20, 1'b0, 1'b1);
        idle(6);
        step(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("mid_rst_busy[%0d]", i),  32'(busy[i]),    32'd0);
            check($sformatf("mid_rst_txd[%0d]", i),   32'(tx_data[i]), 32'd0);
            check($sformatf("mid_rst_alu_a[%0d]", i), 32'(alu_a[i]),   32'd0);
        end
        idle(10);
        for (int i = 0; i < 2; i++) check($sformatf("mid_rst_done[%0d]", i), 32'(done_cnt[i]), 32'd0);
        clear_logs();
        step(1'b1, 8'h10, 8'h22, 8'h21, 1'b0, 1'b1);
        idle(20);
        check_frame("post_rst", 8'hEE, 8'hFD);

        // Random traffic: random done pulses (including spurious ones), clears, resets.
        resp_mode = 0;
        repeat (3000) begin
            step($urandom_range(0, 9) == 0, 8'($urandom), 8'($urandom), 8'($urandom),
                 $urandom_range(0, 29) == 0, !($urandom_range(0, 399) == 0));
        end
        idle(5);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
